ide_pio_ctrl: RTL and testbench
===============================

// Module: ide_pio_ctrl
// PURPOSE
// - Parametrised successor to the single-channel IDE/ROM strobe decoder in the Zorro-II IDE slot.
// - Runs a timed PIO cycle engine (setup / active / recovery) with IORDY wait extension and timeout.
// - Generates the CPU cycle-terminate DTACK_n, and supports one or two IDE channels.
// - Shares the autoconfig window with the boot ROM: ROM on reads until the first write, IDE after.
// PARAMETERS
// NUM_CH      2   IDE channels (1 or 2); with 2, A14 selects the channel
// SETUP_CYC   1   clocks CS-to-strobe address setup (>=1)
// ACTIVE_CYC  3   minimum clocks IOR_n/IOW_n held low (>=1)
// RECOVER_CYC 2   clocks all strobes/CS idle after a cycle, before the next (>=1)
// ROM_WAIT    2   clocks ROM_OE_n low before DTACK_n asserts on a ROM read (>=1)
// IORDY_TMO   16  maximum clocks of IORDY-low extension before forced completion (>=1)
// PORTS
// CLKCPU            in   1          CPU clock; all state changes on rising edge
// RESET_n           in   1          asynchronous active-low reset
// A_HIGH            in   8          CPU A[23:16]
// A12               in   1          CS0 select bit (task file)
// A13               in   1          CS1 select bit (control block)
// A14               in   1          channel select; ignored when NUM_CH==1
// RW_n              in   1          1=read, 0=write
// AS_CPU_n          in   1          CPU address strobe, active low
// BASE_IDE          in   8          autoconfig base A[23:16]
// IDE_CONFIGURED_n  in   1          0 once the board is configured
// IDE_IORDY         in   1          drive IORDY; 0 extends the active phase
// ROM_OE_n          out  1          boot ROM output enable
// IDE_IOR_n         out  1          IDE read strobe (shared by all channels)
// IDE_IOW_n         out  1          IDE write strobe (shared by all channels)
// IDE_CS_n          out  2*NUM_CH   {chN CS1,chN CS0,...}; bit 2c = CS0 of channel c
// IDE_ACCESS        out  1          1 while an IDE cycle owns the data buffers
// DTACK_n           out  1          cycle terminate to CPU, active low
// IORDY_TIMEOUT     out  1          one-clock pulse when the IORDY extension times out
// BEHAVIOUR
// - Reset: ROM_OE_n=1, IOR_n=1, IOW_n=1, all CS_n=1, IDE_ACCESS=0, DTACK_n=1, IORDY_TIMEOUT=0.
//   Reset clears ide_en and forces IDLE from any state, mid-cycle included. All outputs are registered.
// - hit = !IDE_CONFIGURED_n && A_HIGH==BASE_IDE && !AS_CPU_n, sampled only in IDLE.
// - Channel, A12, A13 and RW_n are latched at IDLE exit and held for the whole cycle.
// - ide_en is sticky. It sets on the first write hit and stays set until reset.
// - FSM states:
//   IDLE: hit & RW_n & !ide_en -> ROM; any other hit -> SETUP (a write hit also sets ide_en).
//   ROM: ROM_OE_n=0 for ROM_WAIT clocks, then DTACK_n=0 -> ROMACK.
//   ROMACK: hold ROM_OE_n=0 and DTACK_n=0 until AS_CPU_n=1, then all high -> IDLE.
//     ROM cycles skip RECOVER.
//   SETUP: selected CS_n[2c]=~A12, CS_n[2c+1]=~A13; other channels all 1; IDE_ACCESS=1.
//     Stays SETUP_CYC clocks -> STROBE.
//   STROBE: IOR_n=0 (read) or IOW_n=0 (write) for ACTIVE_CYC clocks, then:
//     IORDY=1 -> ACK;
//     IORDY=0 -> extend, up to IORDY_TMO further clocks;
//     on expiry -> ACK with an IORDY_TIMEOUT pulse.
//   ACK: strobes high, CS held, DTACK_n=0, IDE_ACCESS=1, until AS_CPU_n=1 -> RECOVER.
//   RECOVER: all CS_n=1, strobes high, DTACK_n=1, IDE_ACCESS=0 for RECOVER_CYC clocks -> IDLE.
//     A hit during RECOVER waits; it is not lost.
// - Timing, for a hit sampled at edge k:
//   CS low from k+1;
//   strobe low from k+1+SETUP_CYC;
//   strobe high and DTACK_n low at k+1+SETUP_CYC+ACTIVE_CYC+ext, where ext = IORDY extension clocks.
// - Abort: AS_CPU_n=1 in SETUP/STROBE -> strobes high next edge, no DTACK, -> RECOVER.
//   AS_CPU_n=1 in ROM -> IDLE, no DTACK.
// - IORDY is sampled only after the ACTIVE_CYC minimum has elapsed.
// - Counters are sized $clog2(max param)+1 and never wrap.
// - IOR_n and IOW_n are never low simultaneously; at most one channel's CS is active at a time.
// TESTING
// - Reset, configured, no hit -> every output at its reset value; ide_en=0.
// - Read hit, ide_en=0 -> ROM_OE_n low 2 clocks, then DTACK_n=0 until AS_n high; IOR_n stays 1.
// - Write hit, A12=1, A14=1, IORDY=1:
//   -> CS_n=4'b10xx pattern (ch1 CS0 low) at k+1, IOW_n low at k+2..k+4, DTACK_n low at k+5;
//   -> 2 idle clocks follow; ide_en=1 afterwards.
// - Read after ide_en=1, IORDY low 5 extra clocks -> IOR_n low 8 clocks total, no timeout pulse.
// - IORDY held low -> IOR_n low 3+16 clocks, IORDY_TIMEOUT=1 for one clock, DTACK_n asserts.
// - AS_n deasserted in STROBE -> strobe high next edge, DTACK_n stays 1; RESET_n low mid-ACK -> immediate reset values.

Source files
------------

// File: rtl/ide_pio_ctrl.sv
// IDE PIO cycle engine for the Zorro-II IDE slot.
// Shares the autoconfig window with the boot ROM (ROM on reads until the first
// write), runs timed setup/active/recovery PIO cycles with IORDY extension and
// timeout, and terminates CPU cycles with DTACK_n. Supports one or two channels.
`timescale 1ns/1ps
module ide_pio_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int SETUP_CYC   = 1,
  parameter int ACTIVE_CYC  = 3,
  parameter int RECOVER_CYC = 2,
  parameter int ROM_WAIT    = 2,
  parameter int IORDY_TMO   = 16
) (
  input  logic                  CLKCPU,
  input  logic                  RESET_n,
  input  logic [7:0]            A_HIGH,
  input  logic                  A12,
  input  logic                  A13,
  input  logic                  A14,
  input  logic                  RW_n,
  input  logic                  AS_CPU_n,
  input  logic [7:0]            BASE_IDE,
  input  logic                  IDE_CONFIGURED_n,
  input  logic                  IDE_IORDY,
  output logic                  ROM_OE_n,
  output logic                  IDE_IOR_n,
  output logic                  IDE_IOW_n,
  output logic [2*NUM_CH-1:0]   IDE_CS_n,
  output logic                  IDE_ACCESS,
  output logic                  DTACK_n,
  output logic                  IORDY_TIMEOUT
);

  localparam int M1   = (SETUP_CYC > ACTIVE_CYC) ? SETUP_CYC : ACTIVE_CYC;
  localparam int M2   = (M1 > RECOVER_CYC) ? M1 : RECOVER_CYC;
  localparam int M3   = (M2 > ROM_WAIT) ? M2 : ROM_WAIT;
  localparam int MAXP = (M3 > IORDY_TMO) ? M3 : IORDY_TMO;
  localparam int CW   = $clog2(MAXP) + 1;
  localparam int CSW  = 2 * NUM_CH;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE, ROM, ROMACK, SETUP, STROBE, ACK, RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ext_q, ext_d;
  logic            ide_en_q, ide_en_d;
  logic            rw_q, rw_d;
  logic            rom_oe_n_q, rom_oe_n_d;
  logic            ior_n_q, ior_n_d;
  logic            iow_n_q, iow_n_d;
  logic [CSW-1:0]  cs_n_q, cs_n_d;
  logic            access_q, access_d;
  logic            dtack_n_q, dtack_n_d;
  logic            tmo_q, tmo_d;

  logic hit;
  logic sel_ch;

  assign hit    = !IDE_CONFIGURED_n && (A_HIGH == BASE_IDE) && !AS_CPU_n;
  assign sel_ch = (NUM_CH > 1) ? A14 : 1'b0;

  // Chip selects for the addressed channel; every other channel stays deselected.
  function automatic logic [CSW-1:0] cs_pattern(input logic ch, input logic a12,
                                                input logic a13);
    logic [CSW-1:0] v;
    v = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c[0] == ch) begin
        v[2*c]   = ~a12;
        v[2*c+1] = ~a13;
      end
    end
    return v;
  endfunction

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ext_d      = ext_q;
    ide_en_d   = ide_en_q;
    rw_d       = rw_q;
    rom_oe_n_d = rom_oe_n_q;
    ior_n_d    = ior_n_q;
    iow_n_d    = iow_n_q;
    cs_n_d     = cs_n_q;
    access_d   = access_q;
    dtack_n_d  = dtack_n_q;
    tmo_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          rw_d  = RW_n;
          cnt_d = ONE;
          if (RW_n && !ide_en_q) begin
            state_d    = ROM;
            rom_oe_n_d = 1'b0;
          end else begin
            state_d  = SETUP;
            cs_n_d   = cs_pattern(sel_ch, A12, A13);
            access_d = 1'b1;
            if (!RW_n) ide_en_d = 1'b1;
          end
        end
      end
      ROM: begin
        if (AS_CPU_n) begin
          state_d    = IDLE;
          rom_oe_n_d = 1'b1;
        end else if (cnt_q == CW'(ROM_WAIT)) begin
          state_d   = ROMACK;
          dtack_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ROMACK: begin
        if (AS_CPU_n) begin
          state_d    = IDLE;
          rom_oe_n_d = 1'b1;
          dtack_n_d  = 1'b1;
        end
      end
      SETUP: begin
        if (AS_CPU_n) begin
          state_d  = RECOVER;
          cs_n_d   = '1;
          access_d = 1'b0;
          cnt_d    = ONE;
        end else if (cnt_q == CW'(SETUP_CYC)) begin
          state_d = STROBE;
          cnt_d   = ONE;
          ext_d   = '0;
          if (rw_q) ior_n_d = 1'b0;
          else      iow_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STROBE: begin
        if (AS_CPU_n) begin
          state_d  = RECOVER;
          ior_n_d  = 1'b1;
          iow_n_d  = 1'b1;
          cs_n_d   = '1;
          access_d = 1'b0;
          cnt_d    = ONE;
        end else if (cnt_q != CW'(ACTIVE_CYC)) begin
          cnt_d = cnt_q + ONE;
        end else if (IDE_IORDY || (ext_q == CW'(IORDY_TMO))) begin
          // IORDY only matters once the minimum active time has elapsed.
          state_d   = ACK;
          ior_n_d   = 1'b1;
          iow_n_d   = 1'b1;
          dtack_n_d = 1'b0;
          tmo_d     = !IDE_IORDY;
        end else begin
          ext_d = ext_q + ONE;
        end
      end
      ACK: begin
        if (AS_CPU_n) begin
          state_d   = RECOVER;
          cs_n_d    = '1;
          access_d  = 1'b0;
          dtack_n_d = 1'b1;
          cnt_d     = ONE;
        end
      end
      RECOVER: begin
        if (cnt_q == CW'(RECOVER_CYC)) state_d = IDLE;
        else                           cnt_d   = cnt_q + ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset returns everything to idle immediately.
  always_ff @(posedge CLKCPU or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ext_q      <= '0;
      ide_en_q   <= 1'b0;
      rw_q       <= 1'b1;
      rom_oe_n_q <= 1'b1;
      ior_n_q    <= 1'b1;
      iow_n_q    <= 1'b1;
      cs_n_q     <= '1;
      access_q   <= 1'b0;
      dtack_n_q  <= 1'b1;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ext_q      <= ext_d;
      ide_en_q   <= ide_en_d;
      rw_q       <= rw_d;
      rom_oe_n_q <= rom_oe_n_d;
      ior_n_q    <= ior_n_d;
      iow_n_q    <= iow_n_d;
      cs_n_q     <= cs_n_d;
      access_q   <= access_d;
      dtack_n_q  <= dtack_n_d;
      tmo_q      <= tmo_d;
    end
  end

  assign ROM_OE_n      = rom_oe_n_q;
  assign IDE_IOR_n     = ior_n_q;
  assign IDE_IOW_n     = iow_n_q;
  assign IDE_CS_n      = cs_n_q;
  assign IDE_ACCESS    = access_q;
  assign DTACK_n       = dtack_n_q;
  assign IORDY_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Bench for ide_pio_ctrl: directed CPU cycles, a per-edge expected-output
// timeline built from the cycle timing rules, and an every-cycle compare.
`timescale 1ns/1ps
module tb_ide_pio_ctrl;
  localparam int S = 1, A = 3, R = 2, W = 2, T = 16, NCH = 2, NE = 1024;
  localparam logic [7:0] BASE = 8'hE9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       RESET_n = 1'b0;
  logic [7:0] A_HIGH = 8'h00;
  logic       A12 = 1'b0, A13 = 1'b0, A14 = 1'b0, RW_n = 1'b1, AS_CPU_n = 1'b1;
  logic       IDE_CONFIGURED_n = 1'b0, IDE_IORDY = 1'b1;
  logic       ROM_OE_n, IDE_IOR_n, IDE_IOW_n, IDE_ACCESS, DTACK_n, IORDY_TIMEOUT;
  logic [2*NCH-1:0] IDE_CS_n;

  ide_pio_ctrl #(.NUM_CH(NCH), .SETUP_CYC(S), .ACTIVE_CYC(A), .RECOVER_CYC(R),
                 .ROM_WAIT(W), .IORDY_TMO(T)) dut (
    .CLKCPU(clk), .RESET_n(RESET_n), .A_HIGH(A_HIGH), .A12(A12), .A13(A13),
    .A14(A14), .RW_n(RW_n), .AS_CPU_n(AS_CPU_n), .BASE_IDE(BASE),
    .IDE_CONFIGURED_n(IDE_CONFIGURED_n), .IDE_IORDY(IDE_IORDY),
    .ROM_OE_n(ROM_OE_n), .IDE_IOR_n(IDE_IOR_n), .IDE_IOW_n(IDE_IOW_n),
    .IDE_CS_n(IDE_CS_n), .IDE_ACCESS(IDE_ACCESS), .DTACK_n(DTACK_n),
    .IORDY_TIMEOUT(IORDY_TIMEOUT));

  typedef struct packed {
    logic oe; logic ior; logic iow; logic [3:0] cs; logic acc; logic dtk; logic tmo;
  } outv_t;

  outv_t exp_a [NE];
  int    edge_n = 0;
  int    total = 0, bad = 0;
  bit    chk_en = 1'b0;
  bit    ide_en_m = 1'b0;
  int    next_free = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic outv_t idle_v();
    outv_t v;
    v.oe = 1'b1; v.ior = 1'b1; v.iow = 1'b1; v.cs = 4'hF;
    v.acc = 1'b0; v.dtk = 1'b1; v.tmo = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] cs_pat(input int ch, input bit a12, input bit a13);
    logic [3:0] c;
    c = 4'hF;
    c[2*ch]   = ~a12;
    c[2*ch+1] = ~a13;
    return c;
  endfunction

  // which: 0 IOR low, 1 IOW low, 2 DTACK low, 3 TIMEOUT high, 4 ROM_OE low
  function automatic int cnt_field(input int from, input int to, input int which);
    int n;
    n = 0;
    for (int e = from; e <= to && e < NE; e++) begin
      case (which)
        0: n += (exp_a[e].ior == 1'b0) ? 1 : 0;
        1: n += (exp_a[e].iow == 1'b0) ? 1 : 0;
        2: n += (exp_a[e].dtk == 1'b0) ? 1 : 0;
        3: n += (exp_a[e].tmo == 1'b1) ? 1 : 0;
        default: n += (exp_a[e].oe == 1'b0) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Every cycle: outputs against the timeline, plus the exclusivity rules.
  always @(negedge clk) begin
    if (chk_en) begin
      outv_t act, ex;
      act.oe = ROM_OE_n; act.ior = IDE_IOR_n; act.iow = IDE_IOW_n; act.cs = IDE_CS_n;
      act.acc = IDE_ACCESS; act.dtk = DTACK_n; act.tmo = IORDY_TIMEOUT;
      ex = (edge_n < NE) ? exp_a[edge_n] : idle_v();
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL outputs edge=%0d got=%b want=%b", edge_n, act, ex);
      end
      total++;
      if (IDE_IOR_n == 1'b0 && IDE_IOW_n == 1'b0) begin
        bad++;
        $display("FAIL strobe_excl edge=%0d got ior=0 iow=0 want not both low", edge_n);
      end
      total++;
      if (IDE_CS_n[1:0] != 2'b11 && IDE_CS_n[3:2] != 2'b11) begin
        bad++;
        $display("FAIL cs_excl edge=%0d got=%b want one channel only", edge_n, IDE_CS_n);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    AS_CPU_n = 1'b1;
    A_HIGH = 8'h00;
    repeat (n) step();
  endtask

  // One CPU cycle. ext: IORDY-low samples after the minimum (> T means held low).
  // hold: clocks AS stays low after DTACK; abort_off: AS rises at edge k+abort_off;
  // rst_at: reset asserted this many clocks into the acknowledge.
  task automatic txn(input bit rw, input bit a12, input bit a13, input bit a14,
                     input int ext, input bit early_low, input int hold,
                     input int abort_off, input int rst_at,
                     output int kout, output int aout, output int fout);
    int k, a, fin, eff;
    bit rom, tmo, did_rst;
    outv_t v;
    k = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
    rom = rw && !ide_en_m;
    if (!rw) ide_en_m = 1'b1;
    did_rst = 1'b0;
    if (rom) begin
      a = k + W;
      fin = (abort_off != 0) ? k + abort_off : a + hold + 1;
      for (int e = k; e < fin; e++) begin
        v = idle_v();
        v.oe = 1'b0;
        if (abort_off == 0 && e >= a) v.dtk = 1'b0;
        exp_a[e] = v;
      end
      next_free = fin + 1;
    end else begin
      eff = (ext > T) ? T : ext;
      tmo = (ext > T);
      a = k + S + A + eff;
      fin = (abort_off != 0) ? k + abort_off : a + hold + 1;
      for (int e = k; e < fin; e++) begin
        v = idle_v();
        v.cs = cs_pat(int'(a14), a12, a13);
        v.acc = 1'b1;
        if (e >= k + S && e < a) begin
          if (rw) v.ior = 1'b0;
          else    v.iow = 1'b0;
        end
        if (abort_off == 0 && e >= a) v.dtk = 1'b0;
        if (abort_off == 0 && tmo && e == a) v.tmo = 1'b1;
        exp_a[e] = v;
      end
      next_free = fin + R + 1;
    end
    A_HIGH = BASE; AS_CPU_n = 1'b0; RW_n = rw; A12 = a12; A13 = a13; A14 = a14;
    while (edge_n + 1 <= fin && !did_rst) begin
      int e;
      e = edge_n + 1;
      AS_CPU_n = (e >= fin);
      if (e > k) begin
        A12 = ~a12; A13 = ~a13; A14 = ~a14; RW_n = ~rw;
      end
      IDE_IORDY = !(!rom && ((e >= k + S + A && e < k + S + A + ext) ||
                             (early_low && e < k + S + A)));
      step();
      if (rst_at != 0 && edge_n == a + rst_at) begin
        #2;
        RESET_n = 1'b0;
        for (int x = edge_n; x <= fin && x < NE; x++) exp_a[x] = idle_v();
        ide_en_m = 1'b0;
        #1;
        lit("rst_rom_oe", int'(ROM_OE_n), 1);
        lit("rst_ior", int'(IDE_IOR_n), 1);
        lit("rst_iow", int'(IDE_IOW_n), 1);
        lit("rst_cs", int'(IDE_CS_n), 15);
        lit("rst_access", int'(IDE_ACCESS), 0);
        lit("rst_dtack", int'(DTACK_n), 1);
        lit("rst_tmo", int'(IORDY_TIMEOUT), 0);
        AS_CPU_n = 1'b1;
        did_rst = 1'b1;
      end
    end
    A_HIGH = 8'h00;
    IDE_IORDY = 1'b1;
    AS_CPU_n = 1'b1;
    if (did_rst) begin
      step();
      step();
      RESET_n = 1'b1;
      next_free = edge_n + 1;
    end
    kout = k; aout = a; fout = fin;
  endtask

  initial begin
    int k, a, f, f1;
    for (int i = 0; i < NE; i++) exp_a[i] = idle_v();
    step();
    chk_en = 1'b1;
    step();
    lit("reset_rom_oe", int'(ROM_OE_n), 1);
    lit("reset_ior", int'(IDE_IOR_n), 1);
    lit("reset_iow", int'(IDE_IOW_n), 1);
    lit("reset_cs", int'(IDE_CS_n), 15);
    lit("reset_access", int'(IDE_ACCESS), 0);
    lit("reset_dtack", int'(DTACK_n), 1);
    lit("reset_tmo", int'(IORDY_TIMEOUT), 0);
    step();
    RESET_n = 1'b1;

    // Not configured, then configured with a foreign address: nothing moves.
    IDE_CONFIGURED_n = 1'b1; A_HIGH = BASE; AS_CPU_n = 1'b0; RW_n = 1'b1;
    repeat (4) step();
    IDE_CONFIGURED_n = 1'b0; A_HIGH = 8'hE8;
    repeat (3) step();
    idle(1);

    // Boot ROM read before any write.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2, 0, 0, k, a, f);
    lit("rom_oe_first", int'(exp_a[k].oe), 0);
    lit("rom_dtack_wait", int'(exp_a[k+1].dtk), 1);
    lit("rom_dtack", int'(exp_a[k+2].dtk), 0);
    lit("rom_oe_clocks", cnt_field(k, f, 4), 5);
    lit("rom_no_ior", cnt_field(k, f, 0), 0);

    // ROM read aborted before its acknowledge.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1, 0, k, a, f);
    lit("rom_abort_dtack", cnt_field(k, f, 2), 0);
    idle(2);

    // First write: channel 1 CS0, IORDY ready.
    txn(1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1, 0, 0, k, a, f);
    lit("wr_cs", int'(exp_a[k].cs), 4'b1011);
    lit("wr_iow_setup", int'(exp_a[k].iow), 1);
    lit("wr_iow_first", int'(exp_a[k+1].iow), 0);
    lit("wr_iow_clocks", cnt_field(k, f, 1), 3);
    lit("wr_dtack_edge", int'(exp_a[k+4].dtk), 0);
    lit("wr_iow_end", int'(exp_a[k+4].iow), 1);
    f1 = f;

    // Read issued during recovery: waits, then runs as IDE (ide_en now set).
    txn(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0, 0, k, a, f);
    lit("b2b_gap", k - f1, R + 1);
    lit("b2b_cs", int'(exp_a[k].cs), 4'b1101);
    lit("b2b_no_rom", cnt_field(k, f, 4), 0);
    lit("b2b_ior_clocks", cnt_field(k, f, 0), 3);

    // Five clocks of IORDY extension.
    txn(1'b1, 1'b1, 1'b1, 1'b0, 5, 1'b0, 1, 0, 0, k, a, f);
    lit("ext5_ior_clocks", cnt_field(k, f, 0), 8);
    lit("ext5_tmo", cnt_field(k, f, 3), 0);

    // IORDY held low: forced completion with a timeout pulse.
    txn(1'b1, 1'b1, 1'b0, 1'b1, 40, 1'b0, 1, 0, 0, k, a, f);
    lit("tmo_ior_clocks", cnt_field(k, f, 0), 19);
    lit("tmo_pulses", cnt_field(k, f + R + 2, 3), 1);
    lit("tmo_dtack", int'(exp_a[a].dtk), 0);

    // Write aborted in the strobe phase.
    txn(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 2, 0, k, a, f);
    lit("abort_iow_clocks", cnt_field(k, f + R, 1), 1);
    lit("abort_dtack", cnt_field(k, f + R, 2), 0);
    idle(1);

    // Reset in the middle of an acknowledge, then a read goes to ROM again.
    txn(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 6, 0, 2, k, a, f);
    idle(1);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1, 0, 0, k, a, f);
    lit("post_reset_rom", int'(exp_a[k].oe), 0);
    idle(4);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t want finish before limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
